// File: rtl/cache_fill_fsm_pkg.sv
// Shared constants, state encoding and address helpers for the cache miss-fill controller.
package cache_fill_fsm_pkg;

  localparam int ADDR_W      = 16;
  localparam int WORDS       = 8;
  localparam int OFFSET_BITS = 4;
  localparam int TAG_W       = 5;
  localparam int MEM_LAT     = 4;

  localparam int IDX_W   = $clog2(WORDS);
  localparam int CNT_W   = IDX_W + 1;
  localparam int TAG_MSB = ADDR_W - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FILL  = 2'b01,
    TAGWR = 2'b10
  } state_e;

  // Byte address of the first word of the block containing addr.
  function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/dff.sv
// Generic register cell with write enable and asynchronous active-high reset.
module dff #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wen_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= RST_VAL;
    end else if (wen_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/fill_counter.sv
// Up-counter with enable and synchronous clear; clear takes priority over count.
module fill_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_d;

  assign cnt_d = clr_i ? '0 : cnt_o + W'(1);

  dff #(.W(W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .wen_i (en_i | clr_i),
    .d_i   (cnt_d),
    .q_o   (cnt_o)
  );

endmodule

// File: rtl/cache_fill_fsm.sv
// Miss-fill controller: issues one read per word of the missing block, streams the
// returned words into the data array, then writes the block tag for one cycle.
module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic              mem_read,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic [IDX_W-1:0]  word_index,
  output logic              write_tag_array,
  output logic [TAG_W-1:0]  tag_out
);

  logic [1:0]        state_raw;
  state_e            state_q;
  state_e            state_d;
  logic [ADDR_W-1:0] base_q;
  logic              base_we;
  logic [CNT_W-1:0]  issue_q;
  logic [CNT_W-1:0]  recv_q;
  logic              issue_en;
  logic              recv_en;
  logic              cnt_clr;
  logic              issue_done;
  logic [IDX_W-1:0]  issue_idx;
  logic [ADDR_W-1:0] rd_offset;

  dff #(.W(2), .RST_VAL(2'(IDLE))) u_state (
    .clk   (clk),
    .rst   (rst),
    .wen_i (1'b1),
    .d_i   (2'(state_d)),
    .q_o   (state_raw)
  );

  assign state_q = state_e'(state_raw);

  dff #(.W(ADDR_W)) u_base (
    .clk   (clk),
    .rst   (rst),
    .wen_i (base_we),
    .d_i   (block_base(miss_address)),
    .q_o   (base_q)
  );

  fill_counter #(.W(CNT_W)) u_issue_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (issue_en),
    .clr_i (cnt_clr),
    .cnt_o (issue_q)
  );

  fill_counter #(.W(CNT_W)) u_recv_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (recv_en),
    .clr_i (cnt_clr),
    .cnt_o (recv_q)
  );

  // After the last issue the address stays on the final word of the block.
  assign issue_done = (issue_q == CNT_W'(WORDS));
  assign issue_idx  = issue_done ? IDX_W'(WORDS - 1) : issue_q[IDX_W-1:0];
  assign rd_offset  = ADDR_W'({issue_idx, 1'b0});

  always_comb begin
    state_d          = state_q;
    fsm_busy         = 1'b0;
    mem_read         = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    word_index       = '0;
    write_tag_array  = 1'b0;
    tag_out          = '0;
    base_we          = 1'b0;
    issue_en         = 1'b0;
    recv_en          = 1'b0;
    cnt_clr          = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (miss_detected) begin
          base_we = 1'b1;
          state_d = FILL;
        end
      end

      FILL: begin
        fsm_busy       = 1'b1;
        memory_address = base_q + rd_offset;
        if (!issue_done) begin
          mem_read = 1'b1;
          issue_en = 1'b1;
        end
        // Returns are accepted independently of how many reads are still pending.
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          word_index       = recv_q[IDX_W-1:0];
          recv_en          = 1'b1;
          if (recv_q == CNT_W'(WORDS - 1)) begin
            state_d = TAGWR;
          end
        end
      end

      TAGWR: begin
        fsm_busy        = 1'b1;
        write_tag_array = 1'b1;
        tag_out         = base_q[TAG_MSB -: TAG_W];
        cnt_clr         = 1'b1;
        state_d         = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm: inputs driven on the falling edge, outputs checked 1 ns later.
module tb_cache_fill_fsm;

  logic        clk;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic        fsm_busy;
  logic        mem_read;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  word_index;
  logic        write_tag_array;
  logic [4:0]  tag_out;

  int checks = 0;
  int errors = 0;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .mem_read          (mem_read),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .word_index        (word_index),
    .write_tag_array   (write_tag_array),
    .tag_out           (tag_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  32'(fsm_busy), 0);
    chk({tag, "_rd"},    32'(mem_read), 0);
    chk({tag, "_addr"},  32'(memory_address), 0);
    chk({tag, "_wd"},    32'(write_data_array), 0);
    chk({tag, "_idx"},   32'(word_index), 0);
    chk({tag, "_tagwe"}, 32'(write_tag_array), 0);
    chk({tag, "_tag"},   32'(tag_out), 0);
  endtask

  // Checks for cycle j (1..14) of a fill with reads answered MEM_LAT=4 cycles later.
  task automatic chk_fill_cycle(input int j, input logic [15:0] base, input logic [4:0] tag);
    chk($sformatf("busy_c%0d", j), 32'(fsm_busy), (j <= 13) ? 1 : 0);
    chk($sformatf("rd_c%0d", j), 32'(mem_read), (j <= 8) ? 1 : 0);
    if (j <= 8)
      chk($sformatf("raddr_c%0d", j), 32'(memory_address), 32'(base + 16'(2 * (j - 1))));
    chk($sformatf("wd_c%0d", j), 32'(write_data_array), (j >= 5 && j <= 12) ? 1 : 0);
    if (j >= 5 && j <= 12)
      chk($sformatf("idx_c%0d", j), 32'(word_index), 32'(j - 5));
    chk($sformatf("tagwe_c%0d", j), 32'(write_tag_array), (j == 13) ? 1 : 0);
    chk($sformatf("tag_c%0d", j), 32'(tag_out), (j == 13) ? 32'(tag) : 0);
  endtask

  task automatic run_fill(input logic [15:0] addr, input logic [15:0] base, input logic [4:0] tag);
    @(negedge clk);
    miss_detected = 1'b1;
    miss_address  = addr;
    memory_data_valid = 1'b0;
    #1;
    chk("detect_busy", 32'(fsm_busy), 0);
    chk("detect_noread", 32'(mem_read), 0);
    for (int j = 1; j <= 14; j++) begin
      @(negedge clk);
      miss_detected     = 1'b0;
      memory_data_valid = (j >= 5 && j <= 12);
      #1;
      chk_fill_cycle(j, base, tag);
    end
    memory_data_valid = 1'b0;
    $display("fill addr=%h base=%h tag=%b done", addr, base, tag);
  endtask

  initial begin
    rst = 1'b1;
    miss_detected = 1'b0;
    miss_address = 16'h0000;
    memory_data_valid = 1'b0;
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    $display("reset released");

    // Basic fill
    run_fill(16'h1A36, 16'h1A30, 5'b00011);

    // Valid pulses while idle must not write or count
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      memory_data_valid = 1'b1;
      #1;
      chk("idle_valid_wd", 32'(write_data_array), 0);
      chk("idle_valid_busy", 32'(fsm_busy), 0);
    end
    memory_data_valid = 1'b0;
    $display("idle valid pulses ignored");

    // Stalled memory, plus miss_detected during FILL (different address) ignored
    @(negedge clk);
    miss_detected = 1'b1;
    miss_address  = 16'h2000;
    #1;
    chk("stall_detect_rd", 32'(mem_read), 0);
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      miss_detected     = (k >= 2 && k <= 10);
      miss_address      = 16'h8000;
      memory_data_valid = (k >= 5 && k <= 19 && (k % 2) == 1);
      #1;
      chk($sformatf("stall_busy_c%0d", k), 32'(fsm_busy), (k <= 20) ? 1 : 0);
      chk($sformatf("stall_rd_c%0d", k), 32'(mem_read), (k <= 8) ? 1 : 0);
      if (k <= 19)
        chk($sformatf("stall_addr_c%0d", k), 32'(memory_address),
            (k <= 8) ? 32'(16'h2000 + 16'(2 * (k - 1))) : 32'h200E);
      chk($sformatf("stall_wd_c%0d", k), 32'(write_data_array),
          (k >= 5 && k <= 19 && (k % 2) == 1) ? 1 : 0);
      if (k >= 5 && k <= 19 && (k % 2) == 1)
        chk($sformatf("stall_idx_c%0d", k), 32'(word_index), 32'((k - 5) / 2));
      chk($sformatf("stall_tagwe_c%0d", k), 32'(write_tag_array), (k == 20) ? 1 : 0);
      chk($sformatf("stall_tag_c%0d", k), 32'(tag_out), (k == 20) ? 32'b00100 : 0);
    end
    miss_detected = 1'b0;
    memory_data_valid = 1'b0;
    $display("stalled fill done");

    // Back-to-back: second miss held high, accepted only in the first IDLE cycle
    @(negedge clk);
    miss_detected = 1'b1;
    miss_address  = 16'hFFF0;
    #1;
    chk("b2b_detect_rd", 32'(mem_read), 0);
    for (int k = 1; k <= 28; k++) begin
      @(negedge clk);
      miss_detected = (k <= 14);
      miss_address  = 16'h0004;
      memory_data_valid = (k <= 14) ? (k >= 5 && k <= 12) : ((k - 14) >= 5 && (k - 14) <= 12);
      #1;
      if (k <= 13)
        chk_fill_cycle(k, 16'hFFF0, 5'b11111);
      else if (k == 14) begin
        chk("b2b_idle_busy", 32'(fsm_busy), 0);
        chk("b2b_idle_rd", 32'(mem_read), 0);
      end else
        chk_fill_cycle(k - 14, 16'h0000, 5'b00000);
    end
    miss_detected = 1'b0;
    memory_data_valid = 1'b0;
    $display("back-to-back fills done");

    // Reset after the 3rd data word
    @(negedge clk);
    miss_detected = 1'b1;
    miss_address  = 16'h4A10;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      miss_detected = 1'b0;
      memory_data_valid = (k >= 5);
    end
    #1;
    chk("pre_rst_idx", 32'(word_index), 2);
    @(negedge clk);
    memory_data_valid = 1'b0;
    #1;
    chk("pre_rst_rd", 32'(mem_read), 1);
    chk("pre_rst_busy", 32'(fsm_busy), 1);
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      memory_data_valid = 1'b1;
      #1;
      chk("post_rst_wd", 32'(write_data_array), 0);
      chk("post_rst_tagwe", 32'(write_tag_array), 0);
      chk("post_rst_busy", 32'(fsm_busy), 0);
    end
    memory_data_valid = 1'b0;
    $display("mid-fill reset aborted");

    run_fill(16'h4A10, 16'h4A10, 5'b01001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
